// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter slice.
package regfile_wr_arbiter_pkg;

  typedef logic [4:0]  reg_addr_t;  // RegAddrBus
  typedef logic [31:0] reg_data_t;  // RegBus

  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam logic RstEnable   = 1'b1;

  typedef enum logic {
    PIPE_PRI = 1'b0,
    FORCE    = 1'b1
  } arb_state_e;

  // Register 0 is hardwired; writes to it are accepted but discarded.
  function automatic logic addr_writable(input reg_addr_t a);
    return a != '0;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bus: two requesters in, one registered regfile write port out.
interface regfile_wr_arbiter_if;
  import regfile_wr_arbiter_pkg::*;

  logic      req0_valid;
  reg_addr_t req0_addr;
  reg_data_t req0_data;
  logic      req0_ready;
  logic      req1_valid;
  reg_addr_t req1_addr;
  reg_data_t req1_data;
  logic      req1_ready;
  logic      we;
  reg_addr_t waddr;
  reg_data_t wdata;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, we, waddr, wdata
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, we, waddr, wdata
  );
endinterface

// File: rtl/regfile_wr_arbiter_reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus decode hazard and
// sticky double-issue error.
module reg_scoreboard
  import regfile_wr_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_valid_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_valid_i,
  input  reg_addr_t clr_addr_i,
  input  logic      rd_re1_i,
  input  reg_addr_t rd_addr1_i,
  input  logic      rd_re2_i,
  input  reg_addr_t rd_addr2_i,
  input  logic      dec_wreg_i,
  input  reg_addr_t dec_waddr_i,
  output logic      hazard_o,
  output logic      err_o
);

  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (clr_valid_i) busy_d[clr_addr_i] = 1'b0;
    // Set is applied after clear so a same-cycle issue keeps the bit.
    if (set_valid_i && addr_writable(set_addr_i)) begin
      busy_d[set_addr_i] = 1'b1;
      if (busy_q[set_addr_i]) err_d = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign hazard_o = ((rd_re1_i == ReadEnable) && busy_q[rd_addr1_i])
                  | ((rd_re2_i == ReadEnable) && busy_q[rd_addr2_i])
                  | (dec_wreg_i && busy_q[dec_waddr_i]);
  assign err_o    = err_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the single regfile write port between the MEM/WB stage and a
// long-latency unit, with a starvation counter forcing the latter through.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  regfile_wr_arbiter_if.slave        wb,
  input  logic                       iss_valid,
  input  reg_addr_t                  iss_addr,
  input  logic                       rd_re1,
  input  reg_addr_t                  rd_addr1,
  input  logic                       rd_re2,
  input  reg_addr_t                  rd_addr2,
  input  logic                       dec_wreg,
  input  reg_addr_t                  dec_waddr,
  output logic                       hazard,
  output logic                       stall_req,
  output logic                       err
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       grant0, grant1;
  logic       we_q, we_d;
  reg_addr_t  waddr_q, waddr_d;
  reg_data_t  wdata_q, wdata_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    grant0  = 1'b0;
    grant1  = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    // No grants during reset so a held request is re-presented afterwards.
    if (rst != RstEnable) begin
      unique case (state_q)
        PIPE_PRI: begin
          grant0 = wb.req0_valid;
          grant1 = wb.req1_valid & ~wb.req0_valid;
        end
        FORCE:    grant1 = wb.req1_valid;
        default:  ;
      endcase
    end
    if (wb.req1_valid && !grant1)
      wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 4'd1;
    // Switch on the count that includes this cycle's loss, so FORCE is the
    // (STARVE_LIMIT+1)-th cycle of the wait.
    if (state_q == FORCE)
      state_d = PIPE_PRI;
    else if (wb.req1_valid && wcnt_d == Limit)
      state_d = FORCE;
    if (grant0) begin
      we_d    = addr_writable(wb.req0_addr) ? WriteEnable : ~WriteEnable;
      waddr_d = wb.req0_addr;
      wdata_d = wb.req0_data;
    end else if (grant1) begin
      we_d    = addr_writable(wb.req1_addr) ? WriteEnable : ~WriteEnable;
      waddr_d = wb.req1_addr;
      wdata_d = wb.req1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= PIPE_PRI;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb.req0_ready = grant0;
  assign wb.req1_ready = grant1;
  assign wb.we         = we_q;
  assign wb.waddr      = waddr_q;
  assign wb.wdata      = wdata_q;
  assign stall_req     = (state_q == FORCE);

  reg_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_valid_i (iss_valid),
    .set_addr_i  (iss_addr),
    .clr_valid_i (grant1),
    .clr_addr_i  (wb.req1_addr),
    .rd_re1_i    (rd_re1),
    .rd_addr1_i  (rd_addr1),
    .rd_re2_i    (rd_re2),
    .rd_addr2_i  (rd_addr2),
    .dec_wreg_i  (dec_wreg),
    .dec_waddr_i (dec_waddr),
    .hazard_o    (hazard),
    .err_o       (err)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_regfile_wr_arbiter;
  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       iss_valid, rd_re1, rd_re2, dec_wreg;
  logic [4:0] iss_addr, rd_addr1, rd_addr2, dec_waddr;
  logic       hazard, stall_req, err;

  regfile_wr_arbiter_if bus ();

  regfile_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .wb(bus),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rd_re1(rd_re1), .rd_addr1(rd_addr1), .rd_re2(rd_re2), .rd_addr2(rd_addr2),
    .dec_wreg(dec_wreg), .dec_waddr(dec_waddr),
    .hazard(hazard), .stall_req(stall_req), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  bit          m_busy [32];
  bit          m_err;
  int          m_deny;
  bit          m_force;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  // mid-cycle snapshots of DUT outputs
  logic        s_req0_ready, s_req1_ready, s_hazard, s_stall, s_we, s_err;
  logic [4:0]  s_waddr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_err = 0; m_deny = 0; m_force = 0;
    m_we = 1'b0; m_waddr = '0; m_wdata = '0;
  endtask

  task automatic idle();
    bus.req0_valid = 0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_addr = '0; bus.req1_data = '0;
    iss_valid = 0; iss_addr = '0;
    rd_re1 = 0; rd_addr1 = '0; rd_re2 = 0; rd_addr2 = '0;
    dec_wreg = 0; dec_waddr = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at
  // the edge, then check the registered outputs just after it.
  task automatic cycle();
    bit g0, g1, hz;
    #1;
    g0 = 0; g1 = 0;
    if (!rst) begin
      if (m_force) g1 = bus.req1_valid;
      else begin
        g0 = bus.req0_valid;
        g1 = bus.req1_valid && !bus.req0_valid;
      end
    end
    hz = (rd_re1 && m_busy[rd_addr1]) || (rd_re2 && m_busy[rd_addr2]) ||
         (dec_wreg && m_busy[dec_waddr]);
    s_req0_ready = bus.req0_ready; s_req1_ready = bus.req1_ready;
    s_hazard = hazard; s_stall = stall_req; s_we = bus.we;
    s_waddr = bus.waddr; s_err = err;
    chk("req0_ready", s_req0_ready, g0);
    chk("req1_ready", s_req1_ready, g1);
    chk("stall_req", s_stall, m_force);
    chk("hazard", s_hazard, hz);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (g0) begin
        m_we = (bus.req0_addr != 0); m_waddr = bus.req0_addr; m_wdata = bus.req0_data;
      end else if (g1) begin
        m_we = (bus.req1_addr != 0); m_waddr = bus.req1_addr; m_wdata = bus.req1_data;
      end else m_we = 1'b0;
      if (iss_valid && iss_addr != 0 && m_busy[iss_addr]) m_err = 1;
      if (g1) m_busy[bus.req1_addr] = 0;
      if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1;
      if (bus.req1_valid && !g1) m_deny++;
      else m_deny = 0;
      m_force = (m_deny == LIMIT);
    end
    #1;
    chk("we", bus.we, m_we);
    chk("waddr", bus.waddr, m_waddr);
    chk("wdata", bus.wdata, m_wdata);
    chk("err", err, m_err);
  endtask

  initial begin
    int k;
    bit fs, fr0;
    int p0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    rd_re1 = 1; rd_addr1 = 5;
    cycle();
    rst = 0;
    chk("rst_we", bus.we, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_err", err, 0);

    // plain pipeline write
    idle();
    bus.req0_valid = 1; bus.req0_addr = 5; bus.req0_data = 32'hDEADBEEF;
    cycle();
    chk("r0_ready", s_req0_ready, 1);
    chk("r0_we", bus.we, 1);
    chk("r0_waddr", bus.waddr, 5);
    chk("r0_wdata", bus.wdata, 32'hDEADBEEF);

    // starvation and force grant
    bus.req1_valid = 1; bus.req1_addr = 3; bus.req1_data = 32'h1234;
    k = 0; fs = 0; fr0 = 1;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      cycle();
      if (s_req1_ready) begin k = c; fs = s_stall; fr0 = s_req0_ready; end
    end
    chk("starve_grant_cycle", k, 5);
    chk("force_stall", fs, 1);
    chk("force_r0_ready", fr0, 0);
    bus.req1_valid = 0;
    cycle();
    chk("resume_stall", s_stall, 0);
    chk("resume_r0_ready", s_req0_ready, 1);

    // issue to 9, hazard until the long-latency write lands
    idle();
    iss_valid = 1; iss_addr = 9; rd_re1 = 1; rd_addr1 = 9;
    cycle();
    chk("haz_issue_cycle", s_hazard, 0);
    iss_valid = 0;
    cycle();
    chk("haz_busy", s_hazard, 1);
    bus.req1_valid = 1; bus.req1_addr = 9; bus.req1_data = 32'h99;
    cycle();
    chk("haz_grant_ready", s_req1_ready, 1);
    chk("haz_grant_cycle", s_hazard, 1);
    bus.req1_valid = 0;
    cycle();
    chk("haz_we", s_we, 1);
    chk("haz_waddr", s_waddr, 9);
    chk("haz_clear", s_hazard, 0);

    // same-cycle set and clear of 7, then a double issue
    idle();
    bus.req1_valid = 1; bus.req1_addr = 7; bus.req1_data = 32'h7;
    iss_valid = 1; iss_addr = 7;
    cycle();
    chk("same_ready", s_req1_ready, 1);
    bus.req1_valid = 0; iss_valid = 0; rd_re2 = 1; rd_addr2 = 7;
    cycle();
    chk("same_busy", s_hazard, 1);
    chk("same_noerr", s_err, 0);
    iss_valid = 1;
    cycle();
    chk("err_set", err, 1);
    iss_valid = 0;
    repeat (3) cycle();
    chk("err_sticky", err, 1);

    // grants to register 0
    idle();
    bus.req0_valid = 1; bus.req0_addr = 0; bus.req0_data = 32'h5;
    cycle();
    chk("a0_r0_ready", s_req0_ready, 1);
    chk("a0_r0_we", bus.we, 0);
    bus.req0_valid = 0;
    bus.req1_valid = 1; bus.req1_addr = 0; bus.req1_data = 32'h6;
    cycle();
    chk("a0_r1_ready", s_req1_ready, 1);
    chk("a0_r1_we", bus.we, 0);
    bus.req1_valid = 0;

    // issue to register 0
    iss_valid = 1; iss_addr = 0; rd_re1 = 1; rd_addr1 = 0; dec_wreg = 1; dec_waddr = 0;
    cycle();
    iss_valid = 0;
    cycle();
    chk("iss0_hazard", s_hazard, 0);

    // reset with req1 pending
    idle();
    rd_re1 = 1; rd_addr1 = 7;
    bus.req0_valid = 1; bus.req0_addr = 1; bus.req0_data = 32'h11;
    bus.req1_valid = 1; bus.req1_addr = 2; bus.req1_data = 32'hAA;
    cycle();
    rst = 1;
    cycle();
    chk("rstp_r1_ready", s_req1_ready, 0);
    chk("rstp_we", bus.we, 0);
    chk("rstp_err", err, 0);
    rst = 0; bus.req0_valid = 0;
    cycle();
    chk("rstp_busy", s_hazard, 0);
    chk("rstp_regrant", s_req1_ready, 1);
    bus.req1_valid = 0;

    // randomized traffic; requesters hold until granted
    for (int i = 0; i < 3000; i++) begin
      p0 = (i < 1500) ? 60 : 95;
      if (bus.req0_valid && s_req0_ready) bus.req0_valid = 0;
      if (bus.req1_valid && s_req1_ready) bus.req1_valid = 0;
      if (!bus.req0_valid && $urandom_range(0, 99) < p0) begin
        bus.req0_valid = 1; bus.req0_addr = 5'($urandom_range(0, 31)); bus.req0_data = $urandom;
      end
      if (!bus.req1_valid && $urandom_range(0, 99) < 30) begin
        bus.req1_valid = 1; bus.req1_addr = 5'($urandom_range(0, 7)); bus.req1_data = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 25); iss_addr = 5'($urandom_range(0, 7));
      rd_re1 = 1'($urandom_range(0, 1)); rd_addr1 = 5'($urandom_range(0, 7));
      rd_re2 = 1'($urandom_range(0, 1)); rd_addr2 = 5'($urandom_range(0, 7));
      dec_wreg = 1'($urandom_range(0, 1)); dec_waddr = 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
